// File: rtl/otg_hpi_bus_sequencer.sv
`default_nettype none
// ==== otg_hpi_bus_sequencer : Avalon-MM slave that sequences CY7C67200 HPI read/write cycles (rev 1.0) ====

module otg_hpi_bus_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 6,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  hpi_addr_in,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n
);

    localparam logic [1:0] REG_WDATA  = 2'd0;
    localparam logic [1:0] REG_CMD    = 2'd1;
    localparam logic [1:0] REG_RDATA  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        dir_wr;
    logic        dir_wr_nxt;
    logic [15:0] rdata;
    logic        rd_valid;
    logic        overrun;

    logic        busy;
    logic        wr_acc;
    logic        launch_wr;
    logic        launch_rd;
    logic        launch;
    logic        launch_go;
    logic        status_clr;
    logic        cnt_zero;
    logic        rd_capture;

    logic        cs_n_nxt;
    logic        rd_n_nxt;
    logic        wr_n_nxt;
    logic        oe_nxt;

    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^writedata[31:16];

    assign wr_acc     = chipselect & ~write_n;
    assign launch_wr  = wr_acc & (address == REG_WDATA);
    assign launch_rd  = wr_acc & (address == REG_CMD) & writedata[0];
    assign launch     = launch_wr | launch_rd;
    assign busy       = (state != IDLE);
    assign launch_go  = launch & ~busy;
    assign status_clr = wr_acc & (address == REG_STATUS);
    assign cnt_zero   = (cnt == 4'd0);
    assign rd_capture = (state == STROBE) & cnt_zero & ~dir_wr;

    // Next state and per-phase counter reload
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (launch_go) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Pad controls are decoded from the next state and registered, so pins never glitch
    always_comb begin
        dir_wr_nxt = launch_go ? launch_wr : dir_wr;
        cs_n_nxt   = (state_nxt == IDLE);
        oe_nxt     = ~cs_n_nxt & dir_wr_nxt;
        wr_n_nxt   = ~((state_nxt == STROBE) & dir_wr_nxt);
        rd_n_nxt   = ~((state_nxt == STROBE) & ~dir_wr_nxt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            dir_wr       <= 1'b0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            otg_addr     <= 2'd0;
            otg_data_out <= 16'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            dir_wr      <= dir_wr_nxt;
            otg_cs_n    <= cs_n_nxt;
            otg_rd_n    <= rd_n_nxt;
            otg_wr_n    <= wr_n_nxt;
            otg_data_oe <= oe_nxt;
            if (launch_go) begin
                otg_addr <= hpi_addr_in;
                if (launch_wr) begin
                    otg_data_out <= writedata[15:0];
                end
            end
        end
    end

    // Sticky flags: a set on the same edge as a STATUS clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata    <= 16'd0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rd_capture) begin
                rdata <= otg_data_in;
            end
            if (rd_capture) begin
                rd_valid <= 1'b1;
            end else if (status_clr) begin
                rd_valid <= 1'b0;
            end
            if (launch & busy) begin
                overrun <= 1'b1;
            end else if (status_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        unique case (address)
            REG_RDATA:  readdata = {16'd0, rdata};
            REG_STATUS: readdata = {29'd0, overrun, rd_valid, busy};
            default:    readdata = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_otg_hpi_bus_sequencer.sv
`default_nettype none
// ==== tb_otg_hpi_bus_sequencer : randomized bench against a cycle-count reference model (rev 1.0) ====

module tb_otg_hpi_bus_sequencer;

    localparam int S  = 2;
    localparam int ST = 6;
    localparam int H  = 2;
    localparam int T  = S + ST + H;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  hpi_addr_in;
    logic [1:0]  otg_addr;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;

    otg_hpi_bus_sequencer #(
        .SETUP_CYC  (S),
        .STROBE_CYC (ST),
        .HOLD_CYC   (H)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .hpi_addr_in  (hpi_addr_in),
        .otg_addr     (otg_addr),
        .otg_data_out (otg_data_out),
        .otg_data_oe  (otg_data_oe),
        .otg_data_in  (otg_data_in),
        .otg_cs_n     (otg_cs_n),
        .otg_rd_n     (otg_rd_n),
        .otg_wr_n     (otg_wr_n)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: p counts cycles since the launch edge (0 = idle)
    int          p;
    bit          m_dir_wr;
    logic [1:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_rdata;
    bit          m_rv;
    bit          m_ov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        p        = 0;
        m_dir_wr = 0;
        m_addr   = 2'd0;
        m_data   = 16'd0;
        m_rdata  = 16'd0;
        m_rv     = 0;
        m_ov     = 0;
    endtask

    task automatic model_edge();
        bit acc, launch, clr, set_rv, set_ov;
        acc    = chipselect && !write_n;
        launch = acc && (address == 2'd0 || (address == 2'd1 && writedata[0]));
        clr    = acc && address == 2'd3;
        set_rv = 0;
        set_ov = 0;
        if (p != 0) begin
            if (launch) set_ov = 1;
            if (p == S + ST && !m_dir_wr) begin
                m_rdata = otg_data_in;
                set_rv  = 1;
            end
            p = (p == T) ? 0 : p + 1;
        end else if (launch) begin
            p        = 1;
            m_addr   = hpi_addr_in;
            m_dir_wr = (address == 2'd0);
            if (m_dir_wr) m_data = writedata[15:0];
        end
        if (clr) begin
            m_rv = 0;
            m_ov = 0;
        end
        if (set_rv) m_rv = 1;
        if (set_ov) m_ov = 1;
    endtask

    task automatic check_outputs();
        bit act, strobe;
        logic [31:0] exp_rd;
        act    = (p != 0);
        strobe = act && p > S && p <= S + ST;
        case (address)
            2'd2:    exp_rd = {16'd0, m_rdata};
            2'd3:    exp_rd = {29'd0, m_ov, m_rv, act};
            default: exp_rd = 32'd0;
        endcase
        check("pins{cs_n,rd_n,wr_n,oe}", {28'd0, otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe},
              {28'd0, !act, !(strobe && !m_dir_wr), !(strobe && m_dir_wr), act && m_dir_wr});
        check("otg_addr", {30'd0, otg_addr}, {30'd0, m_addr});
        check("otg_data_out", {16'd0, otg_data_out}, {16'd0, m_data});
        check("readdata", readdata, exp_rd);
    endtask

    task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                        input logic [31:0] wd, input logic [1:0] hpi, input logic [15:0] din);
        @(negedge clk);
        chipselect  = cs;
        write_n     = wn;
        address     = a;
        writedata   = wd;
        hpi_addr_in = hpi;
        otg_data_in = din;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [15:0] din);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)), din);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        address     = 2'd3;
        writedata   = 32'd0;
        hpi_addr_in = 2'd0;
        otg_data_in = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Default write to port 2
        step(1'b1, 1'b0, 2'd0, 32'h1234ABCD, 2'd2, 16'h0);
        idle(11, 16'h0);

        // Read of port 0 returning 0x5A5A, then STATUS read
        step(1'b1, 1'b0, 2'd1, 32'h1, 2'd0, 16'h0);
        idle(10, 16'h5A5A);
        step(1'b0, 1'b1, 2'd2, 32'h0, 2'd0, 16'h0);
        step(1'b0, 1'b1, 2'd3, 32'h0, 2'd0, 16'h0);

        // CMD with bit0=0 and RDATA write are ignored
        step(1'b1, 1'b0, 2'd1, 32'hFFFF_FFFE, 2'd1, 16'h0);
        step(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 2'd1, 16'h0);

        // Overrun at cycle 4, then STATUS clear
        step(1'b1, 1'b0, 2'd0, 32'h0000_1111, 2'd1, 16'h0);
        idle(2, 16'h0);
        step(1'b1, 1'b0, 2'd0, 32'h0000_2222, 2'd3, 16'h0);
        idle(8, 16'h0);
        step(1'b1, 1'b0, 2'd3, 32'h0, 2'd0, 16'h0);
        step(1'b0, 1'b1, 2'd3, 32'h0, 2'd0, 16'h0);

        // Back-to-back writes at the first idle cycle
        step(1'b1, 1'b0, 2'd0, 32'h0000_AAAA, 2'd1, 16'h0);
        idle(10, 16'h0);
        step(1'b1, 1'b0, 2'd0, 32'h0000_5555, 2'd2, 16'h0);
        idle(11, 16'h0);

        // Asynchronous reset in the middle of a write strobe
        step(1'b1, 1'b0, 2'd0, 32'h0000_BEEF, 2'd3, 16'h0);
        idle(3, 16'h0);
        address = 2'd3;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, 2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
